// File: rtl/sigma_delta_pkg.sv
// Shared types and constants for the sigma-delta DAC sample controller.
package sigma_delta_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StRampDown
  } dac_state_e;

  // Offset-binary zero code: 2^(bitlen-1); valid for bitlen in 1..32.
  function automatic logic [31:0] midscale(int unsigned bitlen);
    return 32'h1 << (bitlen - 1);
  endfunction

endpackage

// File: rtl/sigma_delta_dac_ctrl_if.sv
// Valid/ready sample stream feeding the DAC controller.
interface sigma_delta_dac_ctrl_if #(
  parameter int unsigned DAC_BITLEN = 16
) ();

  logic                  s_valid;
  logic                  s_ready;
  logic [DAC_BITLEN-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/sd_sample_fifo.sv
// Synchronous sample buffer with flush; DEPTH must be a power of two >= 2.
module sd_sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + (AW + 1)'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - (AW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/sigma_delta_dac_ctrl.sv
// Paces buffered samples to the modulator once per osr+1 clocks; on disable, ramps to midscale.
module sigma_delta_dac_ctrl
  import sigma_delta_pkg::*;
#(
  parameter int unsigned DAC_BITLEN = 16,
  parameter int unsigned OSR_WIDTH  = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RAMP_STEP  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [OSR_WIDTH-1:0]  osr,
  sigma_delta_dac_ctrl_if.slave smp,
  output logic [DAC_BITLEN-1:0] dac_input,
  output logic                  underflow,
  output logic                  busy
);

  localparam int unsigned          EXT_W    = DAC_BITLEN + 1;
  localparam logic [DAC_BITLEN-1:0] MIDSCALE = DAC_BITLEN'(midscale(DAC_BITLEN));
  localparam logic [DAC_BITLEN:0]   MID_EXT  = {1'b0, MIDSCALE};
  localparam logic [DAC_BITLEN:0]   STEP_EXT = EXT_W'(RAMP_STEP);

  dac_state_e            state_q;
  logic [OSR_WIDTH-1:0]  cnt_q, period_q;
  logic [DAC_BITLEN-1:0] dac_q, ramp_next, fifo_head;
  logic [DAC_BITLEN:0]   dac_ext;
  logic                  tick, push, pop, flush, fifo_full, fifo_empty;

  // period_q holds the osr in force for the running period, so a new osr waits for the wrap.
  assign tick      = (state_q != StIdle) && (cnt_q == period_q);
  assign pop       = tick && (state_q == StRun) && !fifo_empty;
  assign push      = smp.s_valid && smp.s_ready;
  assign flush     = (state_q == StRampDown) && !enable && tick && (dac_q == MIDSCALE);
  assign smp.s_ready = !rst && !fifo_full && (state_q != StRampDown);
  assign underflow = !rst && tick && (state_q == StRun) && fifo_empty;
  assign busy      = (state_q != StIdle);
  assign dac_input = dac_q;

  // Step toward midscale with one spare bit so the compare and add never wrap.
  always_comb begin
    dac_ext   = {1'b0, dac_q};
    ramp_next = MIDSCALE;
    if (dac_ext > MID_EXT) begin
      if (dac_ext - MID_EXT > STEP_EXT) ramp_next = DAC_BITLEN'(dac_ext - STEP_EXT);
    end else if (MID_EXT - dac_ext > STEP_EXT) begin
      ramp_next = DAC_BITLEN'(dac_ext + STEP_EXT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      period_q <= '0;
      dac_q    <= MIDSCALE;
    end else begin
      if (state_q == StIdle) begin
        cnt_q    <= '0;
        period_q <= osr;
      end else if (tick) begin
        cnt_q    <= '0;
        period_q <= osr;
      end else begin
        cnt_q <= cnt_q + OSR_WIDTH'(1);
      end

      unique case (state_q)
        StIdle: begin
          dac_q <= MIDSCALE;
          if (enable) state_q <= StRun;
        end
        StRun: begin
          if (pop) dac_q <= fifo_head;
          if (!enable) state_q <= StRampDown;
        end
        StRampDown: begin
          if (tick) dac_q <= ramp_next;
          if (enable) begin
            state_q <= StRun;
          end else if (flush) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  sd_sample_fifo #(
    .WIDTH (DAC_BITLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (smp.s_data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sigma_delta_dac_ctrl.sv
// Directed scenarios plus randomized traffic, checked every cycle against a queue-based model.
module tb_sigma_delta_dac_ctrl;

  localparam int MID   = 32'h8000;
  localparam int STEP  = 64;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [9:0]  osr = '0;
  logic [15:0] dac_input;
  logic        underflow, busy;

  int n_tests = 0;
  int n_fail  = 0;

  sigma_delta_dac_ctrl_if #(.DAC_BITLEN(16)) smp ();

  sigma_delta_dac_ctrl #(
    .DAC_BITLEN (16),
    .OSR_WIDTH  (10),
    .FIFO_DEPTH (DEPTH),
    .RAMP_STEP  (STEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .osr       (osr),
    .smp       (smp),
    .dac_input (dac_input),
    .underflow (underflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    smp.s_valid = 1'b0;
    smp.s_data  = '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: mode 0 = idle, 1 = playing, 2 = ramping.
  int m_mode = 0;
  int m_cnt  = 0;
  int m_per  = 0;
  int m_dac  = MID;
  int m_q[$];

  function automatic int toward_mid(int d);
    if (d > MID) return (d - MID <= STEP) ? MID : d - STEP;
    return (MID - d <= STEP) ? MID : d + STEP;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      begin
        bit m_tick, e_ready, e_uf, do_push, do_pop;
        int old_mode, old_dac;
        m_tick  = (m_mode != 0) && (m_cnt == m_per);
        e_ready = !rst && (m_q.size() < DEPTH) && (m_mode != 2);
        e_uf    = !rst && m_tick && (m_mode == 1) && (m_q.size() == 0);
        check("dac_input", 32'(dac_input), 32'(m_dac));
        check("underflow", 32'(underflow), 32'(e_uf));
        check("busy", 32'(busy), 32'(m_mode != 0));
        check("s_ready", 32'(smp.s_ready), 32'(e_ready));
        if (rst) begin
          m_mode = 0; m_cnt = 0; m_per = 0; m_dac = MID;
          m_q.delete();
        end else begin
          old_mode = m_mode;
          old_dac  = m_dac;
          do_push  = smp.s_valid && e_ready;
          do_pop   = m_tick && (m_mode == 1) && (m_q.size() > 0);
          if (do_pop) m_dac = m_q.pop_front();
          if (do_push) m_q.push_back(int'(smp.s_data));
          case (old_mode)
            0: begin m_dac = MID; if (enable) m_mode = 1; end
            1: if (!enable) m_mode = 2;
            default: begin
              if (m_tick) m_dac = toward_mid(old_dac);
              if (enable) m_mode = 1;
              else if (m_tick && old_dac == MID) begin
                m_mode = 0;
                m_q.delete();
              end
            end
          endcase
          if (old_mode == 0 || m_tick) begin
            m_cnt = 0;
            m_per = int'(osr);
          end else begin
            m_cnt++;
          end
        end
      end
    end
  end

  task automatic drive(input logic r, input logic e, input int o, input logic v, input int d);
    @(posedge clk);
    #1;
    rst = r; enable = e; osr = 10'(o);
    smp.s_valid = v; smp.s_data = 16'(d);
  endtask

  task automatic wait_idle(input int o);
    int n = 0;
    do begin
      drive(0, 0, o, 0, 0);
      #2;
      n++;
    end while (busy && n < 6000);
    check("reached_idle", 32'(busy), 32'(0));
  endtask

  initial begin
    int uf_seen;
    // Reset and idle
    drive(1, 0, 0, 0, 0); #2;
    check("ready_in_rst", 32'(smp.s_ready), 32'(0));
    drive(0, 0, 0, 0, 0); #2;
    check("ready_after_rst", 32'(smp.s_ready), 32'(1));
    uf_seen = 0;
    for (int j = 0; j < 20; j++) begin
      drive(0, 0, 0, 0, 0); #2;
      if (underflow) uf_seen++;
    end
    check("idle_dac", 32'(dac_input), 32'h8000);
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_ready", 32'(smp.s_ready), 32'(1));
    check("idle_no_uf", 32'(uf_seen), 32'(0));

    // Overfill in idle, then drain at osr=0
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1, 32'h1000 + i * 32'h0111); #2;
      if (i == 3) check("ready_before_4th", 32'(smp.s_ready), 32'(1));
      if (i == 4) check("ready_full", 32'(smp.s_ready), 32'(0));
    end
    drive(0, 0, 0, 1, 32'h1444); #2;
    check("ready_still_full", 32'(smp.s_ready), 32'(0));
    drive(0, 1, 0, 1, 32'h1444);
    for (int j = 1; j <= 7; j++) begin
      drive(0, 1, 0, (j <= 2), 32'h1444); #2;
      if (j == 6) check("fifth_played", 32'(dac_input), 32'h1444);
      if (j == 7) check("drain_uf", 32'(underflow), 32'(1));
    end
    wait_idle(0);

    // Prefill three, play at osr=3
    drive(0, 0, 3, 1, 32'h1000);
    drive(0, 0, 3, 1, 32'h2000);
    drive(0, 0, 3, 1, 32'h3000);
    drive(0, 1, 3, 0, 0);
    for (int j = 1; j <= 13; j++) begin
      drive(0, 1, 3, 0, 0); #2;
      if (j == 4)  check("osr3_before", 32'(dac_input), 32'h8000);
      if (j == 5)  check("osr3_s0", 32'(dac_input), 32'h1000);
      if (j == 8)  check("osr3_hold", 32'(dac_input), 32'h1000);
      if (j == 9)  check("osr3_s1", 32'(dac_input), 32'h2000);
      if (j == 13) check("osr3_s2", 32'(dac_input), 32'h3000);
    end
    wait_idle(3);

    // One sample at osr=0, then continuous underflow
    drive(0, 1, 0, 1, 32'hA000);
    for (int j = 1; j <= 6; j++) begin
      drive(0, 1, 0, 0, 0); #2;
      if (j == 1) check("osr0_first_no_uf", 32'(underflow), 32'(0));
      if (j >= 2) check("osr0_uf", 32'(underflow), 32'(1));
      if (j == 5) check("osr0_hold", 32'(dac_input), 32'hA000);
    end
    wait_idle(0);

    // Ramp from 0x80A0 at osr=1
    drive(0, 0, 1, 1, 32'h80A0);
    drive(0, 1, 1, 0, 0);
    for (int j = 1; j <= 12; j++) begin
      drive(0, (j <= 2), 1, 0, 0); #2;
      if (j == 3)  check("ramp_start", 32'(dac_input), 32'h80A0);
      if (j == 5)  check("ramp_1", 32'(dac_input), 32'h8060);
      if (j == 7)  check("ramp_2", 32'(dac_input), 32'h8020);
      if (j == 9)  check("ramp_3", 32'(dac_input), 32'h8000);
      if (j == 10) check("ramp_busy", 32'(busy), 32'(1));
      if (j == 11) check("ramp_idle", 32'(busy), 32'(0));
      if (j == 11) check("ramp_ready", 32'(smp.s_ready), 32'(1));
    end

    // Reset mid-run with three samples still buffered
    for (int i = 0; i < 4; i++) drive(0, 0, 7, 1, 32'h1111 * (i + 1));
    drive(0, 1, 7, 0, 0);
    for (int j = 1; j <= 13; j++) begin
      drive((j == 10), (j != 11), (j >= 12) ? 0 : 7, 0, 0); #2;
      if (j == 9)  check("rst_pre_dac", 32'(dac_input), 32'h1111);
      if (j == 10) check("rst_no_uf", 32'(underflow), 32'(0));
      if (j == 11) check("rst_dac", 32'(dac_input), 32'h8000);
      if (j == 11) check("rst_busy", 32'(busy), 32'(0));
      if (j == 13) check("rst_flushed_uf", 32'(underflow), 32'(1));
    end
    wait_idle(0);

    // Randomized traffic
    begin
      logic r, e, v;
      int o, d;
      e = 0; o = 1;
      for (int i = 0; i < 4000; i++) begin
        r = ($urandom_range(0, 199) == 0);
        if ($urandom_range(0, 31) == 0) e = !e;
        if ($urandom_range(0, 63) == 0) o = $urandom_range(0, 3);
        v = 1'($urandom_range(0, 1));
        d = int'($urandom_range(0, 65535));
        drive(r, e, o, v, d);
      end
    end
    drive(0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
